// File: rtl/alu_bist_scheduler_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_bist_pkg
// Shared definitions for the ALU runtime self-test scheduler:
//   - FSM state encoding
//   - APB register offsets
//   - CTRL / STATUS bit positions
//   - LFSR polynomial and reset value
// ---------------------------------------------------------------------------
package alu_bist_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        RUN       = 2'd2,
        DONE      = 2'd3
    } bist_state_t;

    // APB register map (byte offsets, word aligned)
    localparam logic [7:0] REG_CTRL    = 8'h00;
    localparam logic [7:0] REG_PERIOD  = 8'h04;
    localparam logic [7:0] REG_STATUS  = 8'h08;
    localparam logic [7:0] REG_ERR_CNT = 8'h0C;
    localparam logic [7:0] REG_RUN_CNT = 8'h10;
    localparam logic [7:0] REG_SEED    = 8'h14;

    // CTRL bits
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_TRIG_BIT   = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    // STATUS bits
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FAIL_BIT  = 1;
    localparam int STAT_ABORT_BIT = 2;

    // Galois LFSR, x^32 + x^22 + x^2 + x + 1
    localparam int          LFSR_W     = 32;
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

endpackage

// File: rtl/alu_bist_scheduler_lfsr.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bist_lfsr
// Right-shifting Galois LFSR used as a pattern source for BIST wrappers.
// Each advance: state = (state >> 1) ^ (state[0] ? TAPS : 0).
// A load of all-zeros is replaced by 1 so the register can never lock up.
// Load has priority over advance.
//
// Ports:
//   clk_i       clock
//   rst_i       asynchronous reset, active-high (state -> RESET_VAL)
//   load_i      load load_val_i this cycle
//   load_val_i  value to load
//   advance_i   step the LFSR once
//   state_o     current LFSR state
// ---------------------------------------------------------------------------
module bist_lfsr #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(32'h8020_0003),
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] state_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] lfsr_reg;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_fix;

    // One Galois step: shift right, fold the outgoing bit into the tap positions.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == WIDTH - 1) begin : g_msb
                assign step_val[gi] = TAPS[gi] & lfsr_reg[0];
            end else begin : g_low
                assign step_val[gi] = lfsr_reg[gi+1] ^ (TAPS[gi] & lfsr_reg[0]);
            end
        end
    endgenerate

    assign load_fix = (load_val_i == '0) ? ONE : load_val_i;

    always_comb begin
        lfsr_next = lfsr_reg;
        if (load_i) begin
            lfsr_next = load_fix;
        end else if (advance_i) begin
            lfsr_next = step_val;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_reg <= RESET_VAL;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign state_o = lfsr_reg;

endmodule

// File: rtl/alu_bist_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_bist_scheduler
// Borrows the shared ALU for short self-test bursts. A run is requested by a
// periodic timer or a software trigger, waits for IDLE_MIN consecutive
// core-sleep cycles, then drives BURST_LEN LFSR patterns as operand A
// (the ALU receives B = ~A, op = ADD, so every good result is all-ones).
// Mismatches are counted and flagged; the core waking mid-run aborts it.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   core_sleep_i          core idle; ALU is free while high
//   bist_active_o         operand mux select (1 = BIST owns the ALU)
//   bist_pattern_o        operand A during a run, 0 otherwise
//   dut_result_i          ALU result for the current-cycle operands
//   paddr_i .. pwdata_i   APB slave inputs
//   prdata_o, pready_o    APB read data, ready (always 1)
//   irq_o                 level interrupt = STATUS.fail & CTRL.irq_en
// ---------------------------------------------------------------------------
module alu_bist_scheduler
    import alu_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8,
    parameter int IDLE_MIN   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  core_sleep_i,
    output logic                  bist_active_o,
    output logic [DATA_WIDTH-1:0] bist_pattern_o,
    input  logic [DATA_WIDTH-1:0] dut_result_i,
    input  logic [7:0]            paddr_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [31:0]           pwdata_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  irq_o
);

    localparam int IDLE_W = $clog2(IDLE_MIN + 1);
    localparam int IDX_W  = $clog2(BURST_LEN + 1);
    localparam logic [IDLE_W-1:0]     IDLE_LAST  = IDLE_W'(IDLE_MIN - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(BURST_LEN - 1);
    // A + ~A is all-ones for every A.
    localparam logic [DATA_WIDTH-1:0] EXP_RESULT = '1;
    localparam logic [CNT_W-1:0]      CNT_MAX    = '1;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic apb_wr, apb_rd;
    logic wr_ctrl, wr_period, wr_status, wr_err, wr_run, wr_seed;
    logic trig_req;

    assign apb_wr    = psel_i & penable_i & pwrite_i;
    assign apb_rd    = psel_i & penable_i & ~pwrite_i;
    assign wr_ctrl   = apb_wr & (paddr_i == REG_CTRL);
    assign wr_period = apb_wr & (paddr_i == REG_PERIOD);
    assign wr_status = apb_wr & (paddr_i == REG_STATUS);
    assign wr_err    = apb_wr & (paddr_i == REG_ERR_CNT);
    assign wr_run    = apb_wr & (paddr_i == REG_RUN_CNT);
    assign wr_seed   = apb_wr & (paddr_i == REG_SEED);

    // A CTRL write always rewrites enable, so a trigger only counts when the
    // same write leaves the block enabled.
    assign trig_req = wr_ctrl & pwdata_i[CTRL_TRIG_BIT] & pwdata_i[CTRL_EN_BIT];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              ctrl_en_reg, ctrl_irq_en_reg;
    logic [CNT_W-1:0]  period_reg;
    logic [CNT_W-1:0]  timer_reg, timer_next;
    logic              timer_fire;
    logic              pending_reg, pending_next;
    bist_state_t       state_reg, state_next;
    logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
    logic [IDX_W-1:0]  pat_idx_reg, pat_idx_next;
    logic              fail_reg, fail_next;
    logic              aborted_reg, aborted_next;
    logic [CNT_W-1:0]  err_cnt_reg, err_cnt_next;
    logic [CNT_W-1:0]  run_cnt_reg, run_cnt_next;

    logic              fsm_active, cmp_en, run_abort, run_done, run_enter;
    logic              mismatch;
    logic [LFSR_W-1:0] lfsr_state;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_en_reg     <= 1'b0;
            ctrl_irq_en_reg <= 1'b0;
            period_reg      <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en_reg     <= pwdata_i[CTRL_EN_BIT];
                ctrl_irq_en_reg <= pwdata_i[CTRL_IRQ_EN_BIT];
            end
            if (wr_period) begin
                period_reg <= pwdata_i[CNT_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Period timer and pending request
    // ------------------------------------------------------------------
    always_comb begin
        timer_fire = 1'b0;
        timer_next = timer_reg;
        if (!ctrl_en_reg || (period_reg == '0)) begin
            timer_next = period_reg;
        end else if (timer_reg <= CNT_W'(1)) begin
            // <= also catches a PERIOD written from 0 while enabled
            timer_fire = 1'b1;
            timer_next = period_reg;
        end else begin
            timer_next = timer_reg - CNT_W'(1);
        end
    end

    always_comb begin
        pending_next = pending_reg;
        if (run_enter || !ctrl_en_reg) begin
            pending_next = 1'b0;
        end
        // A new request in the same cycle must not be lost.
        if (timer_fire || trig_req) begin
            pending_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pending_reg) state_next = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (!ctrl_en_reg) begin
                    state_next = IDLE;
                end else if (core_sleep_i && (idle_cnt_reg == IDLE_LAST)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!core_sleep_i) begin
                    state_next = IDLE;
                end else if (pat_idx_reg == IDX_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        fsm_active = 1'b0;
        cmp_en     = 1'b0;
        run_abort  = 1'b0;
        run_done   = 1'b0;
        case (state_reg)
            RUN: begin
                fsm_active = 1'b1;
                cmp_en     = core_sleep_i;   // compare masked on the abort cycle
                run_abort  = ~core_sleep_i;
            end
            DONE: run_done = 1'b1;
            default: ;
        endcase
    end

    assign run_enter = (state_reg == WAIT_IDLE) && (state_next == RUN);

    // ------------------------------------------------------------------
    // Idle counter and pattern index
    // ------------------------------------------------------------------
    always_comb begin
        idle_cnt_next = '0;
        pat_idx_next  = '0;
        if (state_reg == WAIT_IDLE && core_sleep_i) begin
            idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
        end
        if (state_reg == RUN) begin
            pat_idx_next = pat_idx_reg + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result check, sticky flags, counters
    // ------------------------------------------------------------------
    assign mismatch = cmp_en && (dut_result_i != EXP_RESULT);

    always_comb begin
        fail_next = fail_reg;
        if (wr_status && pwdata_i[STAT_FAIL_BIT]) fail_next = 1'b0;
        if (mismatch) fail_next = 1'b1;

        aborted_next = aborted_reg;
        if (wr_status && pwdata_i[STAT_ABORT_BIT]) aborted_next = 1'b0;
        if (run_abort) aborted_next = 1'b1;

        // Clear beats increment.
        err_cnt_next = err_cnt_reg;
        if (wr_err) begin
            err_cnt_next = '0;
        end else if (mismatch && (err_cnt_reg != CNT_MAX)) begin
            err_cnt_next = err_cnt_reg + CNT_W'(1);
        end

        run_cnt_next = run_cnt_reg;
        if (wr_run) begin
            run_cnt_next = '0;
        end else if (run_done) begin
            run_cnt_next = run_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_reg    <= '0;
            pending_reg  <= 1'b0;
            idle_cnt_reg <= '0;
            pat_idx_reg  <= '0;
            fail_reg     <= 1'b0;
            aborted_reg  <= 1'b0;
            err_cnt_reg  <= '0;
            run_cnt_reg  <= '0;
        end else begin
            timer_reg    <= timer_next;
            pending_reg  <= pending_next;
            idle_cnt_reg <= idle_cnt_next;
            pat_idx_reg  <= pat_idx_next;
            fail_reg     <= fail_next;
            aborted_reg  <= aborted_next;
            err_cnt_reg  <= err_cnt_next;
            run_cnt_reg  <= run_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Pattern generator (SEED write beats the per-cycle advance)
    // ------------------------------------------------------------------
    bist_lfsr #(
        .WIDTH     (LFSR_W),
        .TAPS      (LFSR_TAPS),
        .RESET_VAL (LFSR_RESET)
    ) u_lfsr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (wr_seed),
        .load_val_i (pwdata_i),
        .advance_i  (fsm_active),
        .state_o    (lfsr_state)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bist_active_o  = fsm_active;
    assign bist_pattern_o = fsm_active ? DATA_WIDTH'(lfsr_state) : '0;
    assign pready_o       = 1'b1;
    assign irq_o          = fail_reg & ctrl_irq_en_reg;

    always_comb begin
        prdata_o = '0;
        if (apb_rd) begin
            case (paddr_i)
                REG_CTRL: begin
                    prdata_o[CTRL_EN_BIT]     = ctrl_en_reg;
                    prdata_o[CTRL_IRQ_EN_BIT] = ctrl_irq_en_reg;
                end
                REG_PERIOD:  prdata_o[CNT_W-1:0] = period_reg;
                REG_STATUS: begin
                    prdata_o[STAT_BUSY_BIT]  = (state_reg != IDLE);
                    prdata_o[STAT_FAIL_BIT]  = fail_reg;
                    prdata_o[STAT_ABORT_BIT] = aborted_reg;
                end
                REG_ERR_CNT: prdata_o[CNT_W-1:0] = err_cnt_reg;
                REG_RUN_CNT: prdata_o[CNT_W-1:0] = run_cnt_reg;
                REG_SEED:    prdata_o = lfsr_state;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_scheduler.sv
`timescale 1ns/1ps
module tb_alu_bist_scheduler;
    import alu_bist_pkg::*;

    localparam int BL = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_sleep_i;
    logic        bist_active_o;
    logic [31:0] bist_pattern_o;
    logic [31:0] dut_result_i;
    logic [7:0]  paddr_i = '0;
    logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
    logic [31:0] pwdata_i = '0;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        irq_o;

    // Stimulus knobs (main writes, monitor reads)
    logic sleep_base = 1'b1;
    int   err_mode   = 0;    // 0 none, 1 flip bit0 always, 2 random single-bit flips
    int   abort_at   = -1;   // RUN cycle index where the core wakes
    // Monitor-owned
    logic        kill     = 1'b0;
    logic [31:0] err_mask = '0;
    int          exp_err  = 0;
    logic [31:0] obs_pat[$];
    int          run_len_q[$];
    time         run_start_q[$];
    int          cur_len = 0;
    logic        prev_active = 1'b0;

    int  total = 0, bad = 0;
    int  exp_runs = 0;
    time wr_edge;

    assign core_sleep_i = sleep_base & ~kill;
    // Behavioural ALU: A + B with B = ~A, plus injected corruption.
    assign dut_result_i = (bist_pattern_o + ~bist_pattern_o) ^ err_mask;

    always #5 clk_i = ~clk_i;

    alu_bist_scheduler #(
        .DATA_WIDTH (32), .BURST_LEN (BL), .IDLE_MIN (4), .CNT_W (16)
    ) dut (
        .clk_i (clk_i), .rst_i (rst_i), .core_sleep_i (core_sleep_i),
        .bist_active_o (bist_active_o), .bist_pattern_o (bist_pattern_o),
        .dut_result_i (dut_result_i), .paddr_i (paddr_i), .psel_i (psel_i),
        .penable_i (penable_i), .pwrite_i (pwrite_i), .pwdata_i (pwdata_i),
        .prdata_o (prdata_o), .pready_o (pready_o), .irq_o (irq_o)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %-14s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %-14s got=0x%08h", tag, got);
        end
    endtask

    // Monitor: sample at negedge, record runs, drive ALU corruption / wake-up.
    always @(negedge clk_i) begin
        kill     = 1'b0;
        err_mask = '0;
        if (bist_active_o) begin
            if (!prev_active) begin
                run_start_q.push_back($time);
                cur_len = 0;
            end
            obs_pat.push_back(bist_pattern_o);
            if (cur_len == abort_at) kill = 1'b1;
            if (err_mode == 1) err_mask = 32'h1;
            else if (err_mode == 2 && $urandom_range(1, 0) == 1)
                err_mask = 32'h1 << $urandom_range(31, 0);
            if (err_mask != 0 && sleep_base && !kill) exp_err++;
            cur_len++;
        end else if (prev_active) begin
            run_len_q.push_back(cur_len);
        end
        prev_active = bist_active_o;
    end

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_i);
        paddr_i = a; pwdata_i = d; pwrite_i = 1'b1; psel_i = 1'b1; penable_i = 1'b0;
        @(negedge clk_i);
        penable_i = 1'b1;
        wr_edge = $time + 5;
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk_i);
        paddr_i = a; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b0;
        @(negedge clk_i);
        penable_i = 1'b1;
        #1 d = prdata_o;
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0;
        chk(tag, d, exp);
    endtask

    task automatic wait_runs(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && run_len_q.size() < n; i++) @(negedge clk_i);
        chk(tag, 32'(run_len_q.size() >= n), 32'd1);
    endtask

    // One triggered run: checks length, start latency, patterns, counters, flags.
    task automatic do_run(input string tag, input logic [31:0] seed, input int mode, input int abort_k);
        int n0, p0, e0, len;
        logic [31:0] s;
        time t0;
        apb_write(REG_ERR_CNT, 32'h0);
        apb_write(REG_STATUS, 32'h6);
        apb_write(REG_SEED, seed);
        n0 = run_len_q.size(); p0 = obs_pat.size(); e0 = exp_err;
        err_mode = mode; abort_at = abort_k;
        apb_write(REG_CTRL, 32'h7);
        t0 = wr_edge;
        wait_runs(n0 + 1, 60, {tag, "_wait"});
        err_mode = 0; abort_at = -1;
        len = (abort_k >= 0) ? abort_k + 1 : BL;
        s = (seed == 0) ? 32'h1 : seed;
        if (run_len_q.size() > n0) begin
            chk({tag, "_len"}, 32'(run_len_q[n0]), 32'(len));
            chk({tag, "_start"}, 32'(run_start_q[n0] - t0), 32'd55);
            for (int i = 0; i < len; i++) begin
                chk({tag, "_pat"}, obs_pat[p0 + i], s);
                s = lfsr_step(s);
            end
        end
        if (abort_k < 0) exp_runs++;
        rd_chk({tag, "_err"}, REG_ERR_CNT, 32'(exp_err - e0));
        rd_chk({tag, "_status"}, REG_STATUS,
               {29'b0, abort_k >= 0, exp_err != e0, 1'b0});
        rd_chk({tag, "_runs"}, REG_RUN_CNT, 32'(exp_runs));
        if (abort_k < 0) rd_chk({tag, "_seed"}, REG_SEED, s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        int n0, p0;
        time t0;

        // Reset state
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_active", 32'(bist_active_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_pready", 32'(pready_o), 32'd1);
        rd_chk("rst_ctrl", REG_CTRL, 32'h0);
        rd_chk("rst_period", REG_PERIOD, 32'h0);
        rd_chk("rst_status", REG_STATUS, 32'h0);
        rd_chk("rst_err", REG_ERR_CNT, 32'h0);
        rd_chk("rst_runs", REG_RUN_CNT, 32'h0);
        rd_chk("rst_seed", REG_SEED, 32'h1);
        rd_chk("unmapped", 8'h18, 32'h0);

        apb_write(REG_CTRL, 32'h1);
        do_run("base", 32'h1, 0, -1);
        do_run("bit0", $urandom, 1, -1);
        chk("irq_set", 32'(irq_o), 32'd1);
        apb_write(REG_CTRL, 32'h1);
        chk("irq_masked", 32'(irq_o), 32'd0);
        apb_write(REG_CTRL, 32'h5);
        chk("irq_unmask", 32'(irq_o), 32'd1);
        apb_write(REG_STATUS, 32'h2);
        chk("irq_clear", 32'(irq_o), 32'd0);

        for (int r = 0; r < 3; r++) do_run("rand", $urandom, 2, -1);
        do_run("seed0", 32'h0, 2, -1);
        do_run("abort3", $urandom, 1, 2);
        do_run("abort_r", $urandom, 2, int'($urandom_range(BL - 1, 0)));

        // Periodic runs
        apb_write(REG_CTRL, 32'h0);
        apb_write(REG_RUN_CNT, 32'h0);
        s = $urandom | 32'h1;
        apb_write(REG_SEED, s);
        apb_write(REG_PERIOD, 32'd50);
        n0 = run_len_q.size(); p0 = obs_pat.size();
        apb_write(REG_CTRL, 32'h5);
        t0 = wr_edge;
        wait_runs(n0 + 3, 400, "per_wait");
        if (run_len_q.size() >= n0 + 3) begin
            chk("per_first", 32'(run_start_q[n0] - t0), 32'd555);
            for (int i = 1; i < 3; i++)
                chk("per_gap", 32'(run_start_q[n0 + i] - run_start_q[n0 + i - 1]), 32'd500);
            for (int i = 0; i < 3 * BL; i++) begin
                chk("per_pat", obs_pat[p0 + i], s);
                s = lfsr_step(s);
            end
        end
        rd_chk("per_runs", REG_RUN_CNT, 32'd3);
        apb_write(REG_CTRL, 32'h0);
        repeat (150) @(negedge clk_i);
        chk("per_stopped", 32'(run_len_q.size()), 32'(n0 + 3));
        rd_chk("per_runs2", REG_RUN_CNT, 32'd3);
        rd_chk("per_period", REG_PERIOD, 32'd50);

        // Asynchronous reset in the middle of a run
        err_mode = 1;
        apb_write(REG_CTRL, 32'h7);
        for (int i = 0; i < 30 && !bist_active_o; i++) @(negedge clk_i);
        chk("rst_in_run", 32'(bist_active_o), 32'd1);
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1 chk("rst_async", 32'(bist_active_o), 32'd0);
        err_mode = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd_chk("post_err", REG_ERR_CNT, 32'h0);
        rd_chk("post_status", REG_STATUS, 32'h0);
        rd_chk("post_seed", REG_SEED, 32'h1);
        rd_chk("post_ctrl", REG_CTRL, 32'h0);
        chk("post_irq", 32'(irq_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_bist_scheduler.md
Name: alu_bist_scheduler

Overview:
- Schedules and sequences runtime self-test bursts on the shared Ibex ALU.
- Decides when the ALU may be borrowed: a periodic timer or a software trigger, gated by a minimum core-sleep window.
- Drives the operand-mux select and LFSR patterns, checks ALU results, counts failures and raises an interrupt.
- Sits beside the ALU operand mux; configured over a small APB slave.

Parameters:
- DATA_WIDTH, 32, ALU operand/result width
- BURST_LEN, 8, patterns per run (>=1)
- IDLE_MIN, 4, consecutive core_sleep_i cycles required before a run starts (>=1)
- CNT_W, 16, width of PERIOD, ERR_CNT and RUN_CNT

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- core_sleep_i  in  1  core idle indication; ALU free while high
- bist_active_o  out  1  ALU operand mux select (1 = BIST owns ALU)
- bist_pattern_o  out  DATA_WIDTH  operand A; ALU gets B = ~A, op = ADD
- dut_result_i  in  DATA_WIDTH  ALU result, combinational from same-cycle operands
- paddr_i  in  8  APB address (byte, word aligned)
- psel_i, penable_i, pwrite_i  in  1 each  APB control
- pwdata_i  in  32  APB write data
- prdata_o  out  32  APB read data
- pready_o  out  1  APB ready; constant 1, zero wait states
- irq_o  out  1  level interrupt: STATUS.fail & CTRL.irq_en

Behaviour:
- Reset: all outputs 0, except prdata_o = 0 and pready_o = 1.
- Reset: LFSR = 0x0000_0001, PERIOD = 0, counters = 0, FSM = IDLE.
- Reset is asynchronous: an assertion mid-run drops bist_active_o immediately.
- APB access occurs when psel_i & penable_i. Reads return 0 for unmapped addresses and for reserved bits.
- Register 0x00 CTRL: [0] enable, [1] trigger (write-1 pulse, reads 0), [2] irq_en.
- Register 0x04 PERIOD: cycles between periodic run requests. A value of 0 disables the timer.
- Register 0x08 STATUS: [0] busy (RO), [1] fail, [2] aborted. Bits 1 and 2 are sticky and write-1-to-clear.
- Register 0x0C ERR_CNT: mismatching patterns, saturates at all-ones. Any write clears it.
- Register 0x10 RUN_CNT: completed, non-aborted runs; wraps. Any write clears it.
- Register 0x14 SEED: a write loads the LFSR. A value of 0 is loaded as 1. Reads return the current LFSR value.
- Period timer: while enable=1 and PERIOD!=0, it counts down each cycle.
  - On reaching 1 it sets a pending request and reloads.
  - A trigger write also sets pending.
  - Pending clears when RUN is entered.
  - If enable=0, the timer holds at PERIOD and pending is cleared.
- FSM IDLE: when pending, go to WAIT_IDLE and zero the idle counter.
- FSM WAIT_IDLE:
  - The idle counter increments while core_sleep_i=1 and resets to 0 when it is 0.
  - When it reaches IDLE_MIN, go to RUN with the pattern index at 0.
  - enable=0 returns the FSM to IDLE.
- FSM RUN:
  - bist_active_o=1 and bist_pattern_o = LFSR.
  - Each cycle, expected result = all-ones (A + ~A). A mismatch increments ERR_CNT and sets fail.
  - The LFSR advances once per cycle: Galois, polynomial x^32+x^22+x^2+x+1, taps 0x8020_0003.
  - After BURST_LEN patterns, go to DONE.
- RUN abort: if core_sleep_i=0 in any RUN cycle:
  - That cycle's compare is masked.
  - The FSM goes to IDLE and sets aborted.
  - RUN_CNT is not incremented and bist_active_o is 0 from the next cycle.
- FSM DONE: lasts one cycle with bist_active_o=0. RUN_CNT increments, then the FSM returns to IDLE.
- busy = FSM state is not IDLE.
- Simultaneous trigger write while busy: the request sets pending, so one further run follows.
- Simultaneous SEED write during RUN: the write wins, and the next pattern uses the seed.
- Simultaneous ERR_CNT clear and increment: the clear wins.

Decomposition:
- Shared package alu_bist_pkg holds:
  - FSM state enum (IDLE, WAIT_IDLE, RUN, DONE)
  - register offset constants
  - CTRL/STATUS bit index constants
  - LFSR polynomial constant
- One sub-module: bist_lfsr (load, advance, state out) for reuse by other BIST wrappers.
- APB decode stays inline.

Test Plan:
- Reset with no APB access -> all registers read 0, except SEED reads 0x1. bist_active_o=0 and irq_o=0.
- enable=1, trigger, core_sleep_i=1 steadily -> bist_active_o high for exactly 8 cycles, starting 4 cycles after WAIT_IDLE entry. Patterns follow the LFSR from seed 1. RUN_CNT=1, ERR_CNT=0, STATUS=0.
- As previous, with dut_result_i bit0 flipped during RUN -> ERR_CNT=8 and STATUS.fail=1. irq_o=1 if irq_en; writing STATUS 0x2 clears irq_o.
- core_sleep_i drops on the 3rd RUN cycle -> bist_active_o low next cycle, STATUS.aborted=1, RUN_CNT unchanged. Errors on the dropped cycle are not counted.
- PERIOD=50, core_sleep_i=1 -> successive runs start 50 cycles apart. RUN_CNT=3 after 3 periods. Writing enable=0 stops further runs.
- rst_i asserted mid-RUN -> bist_active_o=0 asynchronously. After release, ERR_CNT=0 and the FSM is IDLE.
